cpu_multicycle: RTL and testbench

Multi-cycle MIPS core that replaces the single-cycle datapath with a state-machine-sequenced datapath. It has a shared instruction/data memory port with a ready handshake, so the core tolerates wait-state memories. It supports branches, jumps, loads and stores, and halts on illegal opcodes. It sits between the testbench/SoC top and a single unified memory model.

---
 rtl/cpu_multicycle.sv | 180 ++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS subset core sequenced by a FETCH/DECODE/EXEC/MEM/WB/HALT state machine.
// One shared memory port serves both instruction fetch and load/store, with a ready handshake.
module cpu_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic        retire,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_R    = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23,
                           OP_SW   = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_NOR  = 6'h27, FN_SLT = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, imm_zext, r_result;
    logic        legal;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Overflow is deliberately ignored: add and addu are the same wrap-around sum.
    always_comb begin
        r_result = '0;
        case (funct)
            FN_ADD, FN_ADDU: r_result = a_q + b_q;
            FN_SUB:          r_result = a_q - b_q;
            FN_AND:          r_result = a_q & b_q;
            FN_OR:           r_result = a_q | b_q;
            FN_NOR:          r_result = ~(a_q | b_q);
            FN_SLT:          r_result = {31'b0, $signed(a_q) < $signed(b_q)};
            default:         r_result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                // PC already points past this instruction, so this is the branch target.
                alu_d = pc_q + {imm_sext[29:0], 2'b00};
                if (!legal) state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
                else        state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_R:        begin alu_d = r_result;              state_d = WB;  end
                    OP_ADDI:     begin alu_d = a_q + imm_sext;        state_d = WB;  end
                    OP_ORI:      begin alu_d = a_q | imm_zext;        state_d = WB;  end
                    OP_LUI:      begin alu_d = {ir_q[15:0], 16'h0};   state_d = WB;  end
                    OP_LW, OP_SW: begin alu_d = a_q + imm_sext;       state_d = MEM; end
                    OP_BEQ:      if (a_q == b_q) pc_d = alu_q;
                    OP_BNE:      if (a_q != b_q) pc_d = alu_q;
                    OP_J:        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    default:     state_d = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    assign rf_we    = (state_q == WB);
    assign rf_waddr = (opcode == OP_R) ? rd : rt;
    assign rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;

    // Entry 0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            DECODE:  retire = !legal && !HALT_ON_ILLEGAL;
            EXEC:    retire = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J);
            MEM:     retire = (opcode == OP_SW) && mem_ready;
            WB:      retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    assign mem_req   = reset && ((state_q == FETCH) || (state_q == MEM));
    assign mem_we    = (state_q == MEM) && (opcode == OP_SW);
    assign mem_addr  = (state_q == MEM) ? {alu_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
    assign mem_wdata = b_q;
    assign pc_out    = pc_q;
    assign halted    = (state_q == HALT);
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: one core halting on illegal opcodes with a controllable
// wait-state memory, plus a second core treating illegal opcodes as NOPs.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic        mem_req, mem_we, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [31:0] mem [0:255];
    int          wr_count = 0;

    logic        ready2 = 1'b1;
    logic        req2, we2, retire2, halted2;
    logic [31:0] addr2, wdata2, rdata2, pc2;
    logic [31:0] mem2 [0:255];

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    cpu_multicycle #(.RESET_PC(32'h0000_0100), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    cpu_multicycle #(.RESET_PC(32'h0000_0000), .HALT_ON_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .reset(reset), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(ready2),
        .pc_out(pc2), .retire(retire2), .halted(halted2)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    assign rdata2    = mem2[addr2[9:2]];

    always @(posedge clk) begin
        if (reset && mem_req && mem_we && mem_ready) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_count = wr_count + 1;
            $display("[%0t] store addr=%h data=%h", $time, mem_addr, mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        if (obs === exp) $display("[%0t] %s = %h ok", $time, tag, obs);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
        if (obs === exp) $display("[%0t] %s = %b ok", $time, tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction from its FETCH cycle; n = cycles up to and including retire.
    task automatic run_instr(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            cycles++;
            if (retire) begin
                tick();
                return;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h0;
            mem2[i] = 32'h0;
        end
        mem[64] = 32'h2001_0005;  // addi $1,$0,5
        mem[65] = 32'h2002_FFFD;  // addi $2,$0,-3
        mem[66] = 32'h0022_1820;  // add  $3,$1,$2
        mem[67] = 32'h0041_2022;  // sub  $4,$2,$1
        mem[68] = 32'h0041_282A;  // slt  $5,$2,$1
        mem[69] = 32'h2000_0007;  // addi $0,$0,7
        mem[70] = 32'hAC01_0008;  // sw   $1,8($0)
        mem[71] = 32'h8C06_0008;  // lw   $6,8($0)
        mem[72] = 32'h1421_0005;  // bne  $1,$1,+5 (not taken)
        mem[73] = 32'h10C1_0002;  // beq  $6,$1,+2 (taken -> 0x130)
        mem[74] = 32'hFC00_0000;
        mem[75] = 32'hFC00_0000;
        mem[76] = 32'h1000_FFFF;  // beq  $0,$0,-1 (self loop)
        mem2[0] = 32'hFC00_0000;  // illegal, retired as NOP
        mem2[1] = 32'h2002_0011;  // addi $2,$0,0x11
        mem2[2] = 32'h1000_FFFF;  // self loop

        repeat (2) tick();
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_retire", retire, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check("rst_pc_out", pc_out, 32'h0000_0100);

        reset = 1'b1;
        #1;
        check1("c1_mem_req", mem_req, 1'b1);
        check1("c1_mem_we", mem_we, 1'b0);
        check("c1_mem_addr", mem_addr, 32'h0000_0100);
        for (int k = 1; k <= 8; k++) begin
            check1($sformatf("retire_c%0d", k), retire, (k == 4) || (k == 8));
            tick();
        end
        check("r1", dut.rf_q[1], 32'd5);
        check("r2", dut.rf_q[2], 32'hFFFF_FFFD);

        run_instr(n); check("add_cycles", n, 4);
        check("r3_add", dut.rf_q[3], 32'd2);
        run_instr(n);
        check("r4_sub", dut.rf_q[4], 32'hFFFF_FFF8);
        run_instr(n);
        check("r5_slt", dut.rf_q[5], 32'd1);
        run_instr(n);
        check("r0_zero", dut.rf_q[0], 32'd0);

        // sw with three wait cycles in MEM
        check("sw_fetch_addr", mem_addr, 32'h0000_0118);
        repeat (3) tick();
        mem_ready = 1'b0;
        #1;
        check1("sw_req", mem_req, 1'b1);
        check1("sw_we", mem_we, 1'b1);
        check("sw_addr", mem_addr, 32'h0000_0008);
        check("sw_wdata", mem_wdata, 32'd5);
        check1("sw_stall_retire", retire, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("sw_addr_hold%0d", k), mem_addr, 32'h0000_0008);
            check($sformatf("sw_wdata_hold%0d", k), mem_wdata, 32'd5);
            check1($sformatf("sw_we_hold%0d", k), mem_we, 1'b1);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check1("sw_retire", retire, 1'b1);
        tick();
        check("sw_mem8", mem[2], 32'd5);
        check("sw_wr_count", wr_count, 32'd1);

        // lw with three wait cycles in MEM: 8 cycles total
        check("lw_fetch_addr", mem_addr, 32'h0000_011C);
        repeat (3) tick();
        mem_ready = 1'b0;
        #1;
        check1("lw_req", mem_req, 1'b1);
        check1("lw_we", mem_we, 1'b0);
        check("lw_addr", mem_addr, 32'h0000_0008);
        tick();
        tick();
        check("lw_addr_hold", mem_addr, 32'h0000_0008);
        tick();
        mem_ready = 1'b1;
        #1;
        check1("lw_mem_retire", retire, 1'b0);
        tick();
        check1("lw_wb_retire_c8", retire, 1'b1);
        tick();
        check("r6_lw", dut.rf_q[6], 32'd5);

        run_instr(n); check("bne_cycles", n, 3);
        check("bne_pc", pc_out, 32'h0000_0124);
        run_instr(n); check("beq_cycles", n, 3);
        check("beq_pc", pc_out, 32'h0000_0130);
        run_instr(n); check("loop1_cycles", n, 3);
        check("loop1_addr", mem_addr, 32'h0000_0130);
        run_instr(n); check("loop2_cycles", n, 3);
        check("loop2_pc", pc_out, 32'h0000_0130);
        check("loop_no_store", wr_count, 32'd1);

        // Reset in the middle of a stalled store
        reset = 1'b0;
        tick();
        mem[64] = 32'h2001_0009;  // addi $1,$0,9
        mem[65] = 32'hAC01_000C;  // sw   $1,12($0)
        mem[66] = 32'h0800_0040;  // j    0x40 -> 0x100
        reset = 1'b1;
        #1;
        run_instr(n);
        check("b_r1", dut.rf_q[1], 32'd9);
        repeat (3) tick();
        mem_ready = 1'b0;
        #1;
        check("b_sw_addr", mem_addr, 32'h0000_000C);
        check("b_sw_wdata", mem_wdata, 32'd9);
        tick();
        reset = 1'b0;
        #1;
        check1("b_rst_req_drop", mem_req, 1'b0);
        check("b_rst_pc", pc_out, 32'h0000_0100);
        tick();
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        check1("b_restart_req", mem_req, 1'b1);
        check("b_restart_addr", mem_addr, 32'h0000_0100);
        check("b_rf_cleared", dut.rf_q[1], 32'd0);
        check("b_no_store", mem[3], 32'd0);
        run_instr(n);
        run_instr(n); check("b_sw_cycles", n, 4);
        check("b_mem12", mem[3], 32'd9);
        run_instr(n); check("j_cycles", n, 3);
        check("j_pc", pc_out, 32'h0000_0100);
        check("j_fetch_addr", mem_addr, 32'h0000_0100);

        // Illegal opcode halts the first core; the second retires it as a NOP
        reset = 1'b0;
        tick();
        mem[64] = 32'h2007_0001;  // addi $7,$0,1
        mem[65] = 32'hFC00_0000;  // opcode 0x3F
        reset = 1'b1;
        #1;
        check1("nop_c1_retire", retire2, 1'b0);
        tick();
        check1("nop_c2_retire", retire2, 1'b1);
        check1("nop_c2_halted", halted2, 1'b0);
        tick();
        tick();
        check1("ill_addi_retire", retire, 1'b1);
        tick();
        check("ill_fetch_addr", mem_addr, 32'h0000_0104);
        tick();
        check1("ill_decode_halted", halted, 1'b0);
        tick();
        check1("ill_halted", halted, 1'b1);
        check1("ill_req", mem_req, 1'b0);
        check("ill_pc", pc_out, 32'h0000_0108);
        repeat (4) tick();
        check1("ill_still_halted", halted, 1'b1);
        check1("ill_still_noreq", mem_req, 1'b0);
        check("ill_pc_frozen", pc_out, 32'h0000_0108);
        check("ill_r7", dut.rf_q[7], 32'd1);
        check("nop_r2", dut2.rf_q[2], 32'h0000_0011);
        check1("nop_not_halted", halted2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
